// File: rtl/controlador_entrada_saida_if.sv
// CPU-side bus of the IO responder.
// Carries the IN/OUT request, store data, read data and the stall.
interface controlador_entrada_saida_if;
  logic [1:0]  entradaSaidaControl;
  logic [31:0] dadosEscrita;
  logic [31:0] DadosLidos;
  logic        pausa;

  modport master (
    output entradaSaidaControl,
    output dadosEscrita,
    input  DadosLidos,
    input  pausa
  );

  modport slave (
    input  entradaSaidaControl,
    input  dadosEscrita,
    output DadosLidos,
    output pausa
  );
endinterface

// File: rtl/controlador_entrada_saida.sv
// IO responder for the CPU IN/OUT instructions.
// Debounced button read and sequential BCD display write.
module controlador_entrada_saida #(
  parameter int LARGURA_ENTRADA = 4,
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int VALOR_MAX       = 999
) (
  input  logic                       clock,
  input  logic                       reset,
  controlador_entrada_saida_if.slave cpu,
  input  logic                       botaoIN,
  input  logic [LARGURA_ENTRADA-1:0] entradaDeDados,
  output logic [3:0]                 unidade,
  output logic [3:0]                 dezena,
  output logic [3:0]                 centena,
  output logic                       estouro
);

  localparam logic [1:0] OCIOSO       = 2'd0;
  localparam logic [1:0] ESPERA_BOTAO = 2'd1;
  localparam logic [1:0] CONVERTE     = 2'd2;
  localparam logic [1:0] CONCLUIDO    = 2'd3;

  localparam int CW = (DEBOUNCE_CICLOS > 1) ?
                      $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic [1:0]    estado;
  logic          sync1;
  logic          sync2;
  logic [CW-1:0] debCnt;
  logic          btnDeb;
  logic          press;
  logic [9:0]    valor;
  logic [11:0]   bcd;
  logic [11:0]   bcdAdj;
  logic [11:0]   bcdNext;
  logic [3:0]    passo;
  logic [31:0]   dadosLidos;
  logic          pedido;

  assign pedido = (cpu.entradaSaidaControl == 2'b01) ||
                  (cpu.entradaSaidaControl == 2'b10);

  // Stall in the same cycle a request shows up, and while busy.
  assign cpu.pausa = reset &&
                     ((estado == ESPERA_BOTAO) ||
                      (estado == CONVERTE) ||
                      ((estado == OCIOSO) && pedido));

  assign cpu.DadosLidos = dadosLidos;

  // A press fires on the cycle the debounced level would rise.
  assign press = sync2 && (debCnt == CNT_MAX) && !btnDeb;

  // Two-flop synchroniser plus saturating debounce counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      debCnt <= '0;
      btnDeb <= 1'b0;
    end else begin
      sync1 <= botaoIN;
      sync2 <= sync1;
      if (!sync2) begin
        debCnt <= '0;
        btnDeb <= 1'b0;
      end else begin
        if (debCnt != CNT_MAX)
          debCnt <= debCnt + CW'(1);
        btnDeb <= (debCnt == CNT_MAX);
      end
    end
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift in.
  always_comb begin
    bcdAdj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcdAdj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcdNext = {bcdAdj[10:0], valor[9]};
  end

  // Request sequencing, capture and conversion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      dadosLidos <= '0;
      unidade    <= '0;
      dezena     <= '0;
      centena    <= '0;
      estouro    <= 1'b0;
      valor      <= '0;
      bcd        <= '0;
      passo      <= '0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (cpu.entradaSaidaControl == 2'b01) begin
            estado <= ESPERA_BOTAO;
          end else if (cpu.entradaSaidaControl == 2'b10) begin
            estado <= CONVERTE;
            bcd    <= '0;
            passo  <= '0;
            if (cpu.dadosEscrita > 32'(VALOR_MAX)) begin
              valor   <= 10'(VALOR_MAX);
              estouro <= 1'b1;
            end else begin
              valor   <= cpu.dadosEscrita[9:0];
              estouro <= 1'b0;
            end
          end
        end
        ESPERA_BOTAO: begin
          if (press) begin
            dadosLidos <= 32'(entradaDeDados);
            estado     <= CONCLUIDO;
          end
        end
        CONVERTE: begin
          bcd   <= bcdNext;
          valor <= {valor[8:0], 1'b0};
          passo <= passo + 4'd1;
          if (passo == 4'd9) begin
            centena <= bcdNext[11:8];
            dezena  <= bcdNext[7:4];
            unidade <= bcdNext[3:0];
            estado  <= CONCLUIDO;
          end
        end
        CONCLUIDO: begin
          estado <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Bench for controlador_entrada_saida.
// Cycle model from the behavioural rules, directed cases plus random traffic.
module tb_controlador_entrada_saida;
  localparam int LW   = 4;
  localparam int DEB  = 4;
  localparam int VMAX = 999;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          botaoIN = 1'b0;
  logic [LW-1:0] sw = '0;
  logic [3:0]    unidade;
  logic [3:0]    dezena;
  logic [3:0]    centena;
  logic          estouro;

  controlador_entrada_saida_if cpu();

  controlador_entrada_saida #(
    .LARGURA_ENTRADA(LW),
    .DEBOUNCE_CICLOS(DEB),
    .VALOR_MAX(VMAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu(cpu),
    .botaoIN(botaoIN),
    .entradaDeDados(sw),
    .unidade(unidade),
    .dezena(dezena),
    .centena(centena),
    .estouro(estouro)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: raw button history and busy bookkeeping.
  logic [DEB:0] hist;
  logic         debPrev;
  logic         debNow;
  logic         mPress;
  logic         mWait;
  int           mLeft;
  logic         mDone;
  int           mPend;
  logic [31:0]  mLidos;
  logic [3:0]   mC, mD, mU;
  logic         mE;
  logic         expPausa;

  // Level is high once the last DEB synced samples (raw delayed 2) are all high.
  assign debNow = &hist[DEB:1];
  assign mPress = debNow && !debPrev;
  assign expPausa = reset && (mWait || (mLeft > 0) ||
                    (!mDone && ((cpu.entradaSaidaControl == 2'b01) ||
                                (cpu.entradaSaidaControl == 2'b10))));

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist    <= '0;
      debPrev <= 1'b0;
      mWait   <= 1'b0;
      mLeft   <= 0;
      mDone   <= 1'b0;
      mPend   <= 0;
      mLidos  <= '0;
      mC      <= '0;
      mD      <= '0;
      mU      <= '0;
      mE      <= 1'b0;
    end else begin
      hist    <= {hist[DEB-1:0], botaoIN};
      debPrev <= debNow;
      if (mDone) begin
        mDone <= 1'b0;
      end else if (mWait) begin
        if (mPress) begin
          mLidos <= 32'(sw);
          mWait  <= 1'b0;
          mDone  <= 1'b1;
        end
      end else if (mLeft > 0) begin
        mLeft <= mLeft - 1;
        if (mLeft == 1) begin
          mC    <= 4'(mPend / 100);
          mD    <= 4'((mPend / 10) % 10);
          mU    <= 4'(mPend % 10);
          mDone <= 1'b1;
        end
      end else if (cpu.entradaSaidaControl == 2'b01) begin
        mWait <= 1'b1;
      end else if (cpu.entradaSaidaControl == 2'b10) begin
        mLeft <= 10;
        if (cpu.dadosEscrita > 32'(VMAX)) begin
          mPend <= VMAX;
          mE    <= 1'b1;
        end else begin
          mPend <= int'(cpu.dadosEscrita);
          mE    <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clock) begin
    chk("pausa", 32'(cpu.pausa), 32'(expPausa));
    chk("DadosLidos", cpu.DadosLidos, mLidos);
    chk("digitos", 32'({centena, dezena, unidade}), 32'({mC, mD, mU}));
    chk("estouro", 32'(estouro), 32'(mE));
  end

  task automatic doOut(input logic [31:0] val, input logic [3:0] c,
                       input logic [3:0] d, input logic [3:0] u,
                       input logic e);
    int n;
    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b10;
    cpu.dadosEscrita = val;
    #1;
    n = cpu.pausa ? 1 : 0;
    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b00;
    cpu.dadosEscrita = $urandom;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!cpu.pausa) break;
      n++;
    end
    chk("out_pausa_ciclos", 32'(n), 32'd11);
    chk("out_bcd", 32'({centena, dezena, unidade}), 32'({c, d, u}));
    chk("out_estouro", 32'(estouro), 32'(e));
  endtask

  initial begin
    int n;
    int r;
    cpu.entradaSaidaControl = 2'b00;
    cpu.dadosEscrita = '0;
    #3;
    chk("rst_pausa", 32'(cpu.pausa), 32'd0);
    chk("rst_digitos", 32'({centena, dezena, unidade}), 32'd0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    doOut(32'd427, 4'd4, 4'd2, 4'd7, 1'b0);
    doOut(32'd5000, 4'd9, 4'd9, 4'd9, 1'b1);
    doOut(32'd999, 4'd9, 4'd9, 4'd9, 1'b0);
    doOut(32'd0, 4'd0, 4'd0, 4'd0, 1'b0);

    doOut(32'd318, 4'd3, 4'd1, 4'd8, 1'b0);
    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b11;
    #1 chk("req11_pausa", 32'(cpu.pausa), 32'd0);
    doOut(32'd1000, 4'd9, 4'd9, 4'd9, 1'b1);
    doOut(32'd56, 4'd0, 4'd5, 4'd6, 1'b0);

    doOut(32'd123, 4'd1, 4'd2, 4'd3, 1'b0);
    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b10;
    cpu.dadosEscrita = 32'd456;
    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b00;
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    cpu.entradaSaidaControl = 2'b10;
    #1;
    chk("async_rst_pausa", 32'(cpu.pausa), 32'd0);
    chk("async_rst_digitos", 32'({centena, dezena, unidade}), 32'd0);
    chk("async_rst_estouro", 32'(estouro), 32'd0);
    chk("async_rst_lidos", cpu.DadosLidos, 32'd0);
    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b00;
    reset = 1'b1;
    repeat (12) @(posedge clock);
    #1 chk("no_partial_digitos", 32'({centena, dezena, unidade}), 32'd0);

    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b01;
    sw = 4'hA;
    #1 chk("in_req_pausa", 32'(cpu.pausa), 32'd1);
    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b00;
    botaoIN = 1'b1;
    @(posedge clock); #2;
    @(posedge clock); #2;
    botaoIN = 1'b0;
    repeat (6) @(posedge clock);
    #2;
    chk("bounce_pausa", 32'(cpu.pausa), 32'd1);
    chk("bounce_lidos", cpu.DadosLidos, 32'd0);
    botaoIN = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("press_early_lidos", cpu.DadosLidos, 32'd0);
    chk("press_early_pausa", 32'(cpu.pausa), 32'd1);
    @(posedge clock); #1;
    chk("press_lidos", cpu.DadosLidos, 32'd10);
    chk("press_pausa", 32'(cpu.pausa), 32'd0);

    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b00;
    repeat (8) @(posedge clock);
    #2;
    cpu.entradaSaidaControl = 2'b01;
    sw = 4'd3;
    #1 chk("held_req_pausa", 32'(cpu.pausa), 32'd1);
    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b00;
    repeat (10) @(posedge clock);
    #1;
    chk("held_pausa", 32'(cpu.pausa), 32'd1);
    chk("held_lidos", cpu.DadosLidos, 32'd10);
    #1;
    sw = 4'd5;
    botaoIN = 1'b0;
    repeat (3) @(posedge clock);
    #2 botaoIN = 1'b1;
    for (n = 0; n < 30; n++) begin
      if (!cpu.pausa) break;
      @(posedge clock); #1;
    end
    chk("repress_latencia", 32'(n), 32'd6);
    chk("repress_lidos", cpu.DadosLidos, 32'd5);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #2;
      r = $urandom_range(0, 9);
      if (r < 5)
        cpu.entradaSaidaControl = 2'b00;
      else if (r < 7)
        cpu.entradaSaidaControl = 2'b10;
      else if (r < 8)
        cpu.entradaSaidaControl = 2'b01;
      else
        cpu.entradaSaidaControl = 2'b11;
      if ($urandom_range(0, 3) == 0)
        cpu.dadosEscrita = $urandom;
      else
        cpu.dadosEscrita = 32'($urandom_range(0, 1100));
      if ($urandom_range(0, 4) == 0)
        botaoIN = ~botaoIN;
      sw = LW'($urandom);
    end
    @(posedge clock); #2;
    cpu.entradaSaidaControl = 2'b00;
    botaoIN = 1'b0;
    repeat (40) @(posedge clock);
    botaoIN = 1'b1;
    repeat (20) @(posedge clock);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
